pim_chunk_dispatcher: RTL and testbench
=======================================

Name: pim_chunk_dispatcher

Overview:
- Upstream feeder for the PIM array. For one output element C[row][col], it fetches row `row` of A and column `col` of B from the shared word-addressed matrix memory.
- It packs operand pairs into chunks of PIM_UNIT_CAPACITY elements each.
- Chunks go round-robin to the NUM_OF_PIM_UNITS units over a valid/ready channel.
- It sits between the matrix memory and the PIM unit array.

Parameters:
- DIM, 16, square matrix dimension; must be a multiple of CAP. A and B are both row-major.
- CAP, types::PIM_UNIT_CAPACITY (2), element pairs per chunk.
- UNITS, types::NUM_OF_PIM_UNITS (4), number of PIM units targeted round-robin.
- W, types::WIDTH (32), data width.
- AW, types::LEN (10), memory address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_a  in  AW  address of A[0][0].
- base_b  in  AW  address of B[0][0].
- row_idx  in  $clog2(DIM)  row of A.
- col_idx  in  $clog2(DIM)  column of B.
- mem_rd  out  1  read strobe.
- mem_addr  out  AW  read address.
- mem_rdata  in  W  read data; valid the cycle after mem_rd.
- chunk_valid  out  1  chunk available.
- chunk_ready  in  1  consumer accepts.
- chunk_unit  out  $clog2(UNITS)  destination PIM unit.
- chunk_a  out  CAP*W  A operands; element k of the chunk in bits [k*W +: W].
- chunk_b  out  CAP*W  B operands; same packing.
- chunk_last  out  1  final chunk of the dot product.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after the final chunk handshake.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - state=IDLE.
  - mem_rd, chunk_valid, chunk_last, busy, done all 0.
  - mem_addr, chunk_unit, chunk_a, chunk_b all 0.
  - Chunk counter and unit pointer cleared.
  - Reset mid-operation abandons the transfer. No done pulse is issued.
- State machine states: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - On start=1, latch base_a, base_b, row_idx and col_idx.
  - Clear the chunk counter c and the unit pointer.
  - Go to FETCH.
- FETCH, 2*CAP cycles, mem_rd=1 every cycle:
  - First CAP cycles read A[row][c*CAP+k] at base_a + row*DIM + c*CAP + k.
  - Next CAP cycles read B[c*CAP+k][col] at base_b + (c*CAP+k)*DIM + col.
  - All address arithmetic is modulo 2^AW; wrap-around is silent.
  - Each returned word is captured one cycle after its read into the matching chunk_a/chunk_b slot.
- WAIT, 1 cycle, mem_rd=0:
  - Captures the last B word.
  - Go to SEND.
- SEND:
  - chunk_valid=1; chunk_last = (c == DIM/CAP-1).
  - chunk_a, chunk_b, chunk_unit and chunk_last are held stable while valid && !ready.
  - On valid && ready, the unit pointer advances modulo UNITS.
  - If last, go to DONE; otherwise increment c and go to FETCH.
  - chunk_valid falls the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency with start sampled at edge 0 and CAP=2:
  - Reads are issued in cycles 1–4, WAIT is cycle 5, chunk_valid rises in cycle 6.
  - Per-chunk throughput is 2*CAP+2 cycles with ready tied high.
- start while busy is ignored; there is no queueing.
- chunk_unit starts at 0 on every new request.

Decomposition:
- Shared package `types` gains:
  - DIM default constant.
  - Typedef `word_t` (logic [WIDTH-1:0]).
  - Typedef `addr_t` (logic [LEN-1:0]).
  - Typedef `unit_id_t` (logic [$clog2(NUM_OF_PIM_UNITS)-1:0]).
  - The dispatcher state enum.
- No sub-module. Address generation and the capture register file stay inline in one module.
- Elaboration assertion: DIM % CAP == 0.

Test Plan:
- Single request, ready=1:
  - Setup: mem[a]=a, DIM=16, CAP=2, UNITS=4, base_a=0, base_b=256, row=1, col=2.
  - 8 chunks with chunk_unit 0,1,2,3,0,1,2,3.
  - chunk0: a={17,16}, b={274,258}.
  - chunk7: a={31,30}, b={498,482}, chunk_last=1.
  - done pulses once, the cycle after the chunk7 handshake.
- Latency check: start at edge 0 gives mem_rd high in cycles 1–4 with addresses 16,17,258,274, and the first chunk_valid in cycle 6.
- Backpressure:
  - ready low for 5 cycles on chunk 3.
  - Outputs stay stable throughout; no extra mem_rd.
  - Resumes correctly; total chunk count is still 8.
- Address wrap:
  - base_b=1000, col=0.
  - B reads hit 1000, 1016, then 8 and 24 (wrapped modulo 1024).
  - Captured data matches mem at those addresses.
- start pulsed while busy:
  - Ignored. Only 8 chunks; addresses unchanged.
  - A new start after done restarts chunk_unit at 0.
- rst_n asserted during SEND of chunk 2:
  - All outputs are 0 immediately (asynchronous).
  - No done pulse.
  - After release, a fresh request completes normally.

Source files
------------

// File: rtl/pim_chunk_dispatcher_pkg.sv
// Shared PIM type definitions: widths, unit count, matrix dimension and the
// chunk dispatcher state encoding.
package types;

  localparam int unsigned WIDTH             = 32;
  localparam int unsigned LEN               = 10;
  localparam int unsigned PIM_UNIT_CAPACITY = 2;
  localparam int unsigned NUM_OF_PIM_UNITS  = 4;
  localparam int unsigned DIM               = 16;

  typedef logic [WIDTH-1:0]                    word_t;
  typedef logic [LEN-1:0]                      addr_t;
  typedef logic [$clog2(NUM_OF_PIM_UNITS)-1:0] unit_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } disp_state_e;

endpackage

// File: rtl/pim_chunk_dispatcher.sv
// Fetches one row of A and one column of B, packs operand pairs into chunks and
// hands them round-robin to the PIM units over a valid/ready channel.
module pim_chunk_dispatcher
  import types::*;
#(
  parameter int unsigned DIM   = types::DIM,
  parameter int unsigned CAP   = types::PIM_UNIT_CAPACITY,
  parameter int unsigned UNITS = types::NUM_OF_PIM_UNITS,
  parameter int unsigned W     = types::WIDTH,
  parameter int unsigned AW    = types::LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            base_a,
  input  logic [AW-1:0]            base_b,
  input  logic [$clog2(DIM)-1:0]   row_idx,
  input  logic [$clog2(DIM)-1:0]   col_idx,
  output logic                     mem_rd,
  output logic [AW-1:0]            mem_addr,
  input  logic [W-1:0]             mem_rdata,
  output logic                     chunk_valid,
  input  logic                     chunk_ready,
  output logic [$clog2(UNITS)-1:0] chunk_unit,
  output logic [CAP*W-1:0]         chunk_a,
  output logic [CAP*W-1:0]         chunk_b,
  output logic                     chunk_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NCH = DIM / CAP;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned KW  = $clog2(2 * CAP);
  localparam int unsigned RW  = $clog2(DIM);
  localparam int unsigned UW  = $clog2(UNITS);

  if (DIM % CAP != 0) begin : g_dim_chk
    $error("pim_chunk_dispatcher: DIM must be a multiple of CAP");
  end

  disp_state_e           state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [KW-1:0]         k_q, k_d;
  logic [UW-1:0]         unit_q, unit_d;
  logic [AW-1:0]         base_a_q, base_a_d, base_b_q, base_b_d;
  logic [RW-1:0]         row_q, row_d, col_q, col_d;
  logic                  pend_q, pend_d;
  logic [KW-1:0]         slot_q, slot_d;
  logic [CAP-1:0][W-1:0] a_q, a_d, b_q, b_d;

  logic                  last_chunk;
  logic [AW-1:0]         elem, a_addr, b_addr;

  assign last_chunk = (c_q == CW'(NCH - 1));

  // Element index within the dot product; reads 0..CAP-1 are A, CAP..2*CAP-1 are B.
  always_comb begin
    elem   = AW'(c_q) * AW'(CAP)
           + ((k_q < KW'(CAP)) ? AW'(k_q) : AW'(k_q - KW'(CAP)));
    a_addr = base_a_q + AW'(row_q) * AW'(DIM) + elem;
    b_addr = base_b_q + elem * AW'(DIM) + AW'(col_q);
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    k_d      = k_q;
    unit_d   = unit_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    row_d    = row_q;
    col_d    = col_q;
    pend_d   = 1'b0;
    slot_d   = k_q;
    a_d      = a_q;
    b_d      = b_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          row_d    = row_idx;
          col_d    = col_idx;
          c_d      = '0;
          k_d      = '0;
          unit_d   = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pend_d = 1'b1;
        if (k_q == KW'(2 * CAP - 1)) begin
          k_d     = '0;
          state_d = ST_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: begin
        if (chunk_ready) begin
          unit_d = (unit_q == UW'(UNITS - 1)) ? '0 : unit_q + 1'b1;
          if (last_chunk) begin
            state_d = ST_DONE;
          end else begin
            c_d     = c_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Read data lands one cycle after its strobe; slot_q remembers where it goes.
    if (pend_q) begin
      for (int unsigned i = 0; i < CAP; i++) begin
        if (32'(slot_q) == i)       a_d[i] = mem_rdata;
        if (32'(slot_q) == i + CAP) b_d[i] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      k_q      <= '0;
      unit_q   <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      pend_q   <= 1'b0;
      slot_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      k_q      <= k_d;
      unit_q   <= unit_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      row_q    <= row_d;
      col_q    <= col_d;
      pend_q   <= pend_d;
      slot_q   <= slot_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign mem_rd      = (state_q == ST_FETCH);
  assign mem_addr    = (state_q != ST_FETCH) ? '0 : (k_q < KW'(CAP)) ? a_addr : b_addr;
  assign chunk_valid = (state_q == ST_SEND);
  assign chunk_last  = (state_q == ST_SEND) && last_chunk;
  assign chunk_unit  = unit_q;
  assign chunk_a     = a_q;
  assign chunk_b     = b_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_pim_chunk_dispatcher.sv
// Bench for pim_chunk_dispatcher: directed requests plus randomized memory,
// operands and backpressure against a dot-product operand reference model.
module tb_pim_chunk_dispatcher;

  localparam int DIM   = 16;
  localparam int CAP   = 2;
  localparam int UNITS = 4;
  localparam int W     = 32;
  localparam int AW    = 10;
  localparam int NCH   = DIM / CAP;
  localparam int MSZ   = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_a, base_b;
  logic [3:0]       row_idx, col_idx;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [W-1:0]     mem_rdata;
  logic             chunk_valid;
  logic             chunk_ready;
  logic [1:0]       chunk_unit;
  logic [CAP*W-1:0] chunk_a, chunk_b;
  logic             chunk_last;
  logic             busy;
  logic             done;

  pim_chunk_dispatcher #(.DIM(DIM), .CAP(CAP), .UNITS(UNITS), .W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .row_idx(row_idx), .col_idx(col_idx), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
    .chunk_unit(chunk_unit), .chunk_a(chunk_a), .chunk_b(chunk_b),
    .chunk_last(chunk_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:MSZ-1];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_asserts = 0;
  int n_fail    = 0;

  logic [CAP*W-1:0] exp_a [NCH];
  logic [CAP*W-1:0] exp_b [NCH];
  int               exp_addr[$];
  int               rd_log[$];
  logic [CAP*W-1:0] obs_a0, obs_b0, obs_a7, obs_b7;
  logic             obs_last7;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected reads and chunk contents straight from the row/column element formulas.
  task automatic build_model(input int ba, input int bb, input int row, input int col);
    int ad;
    exp_addr.delete();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < CAP; k++) begin
        ad = (ba + row * DIM + c * CAP + k) % MSZ;
        exp_addr.push_back(ad);
        exp_a[c][k*W +: W] = mem[ad];
      end
      for (int k = 0; k < CAP; k++) begin
        ad = (bb + (c * CAP + k) * DIM + col) % MSZ;
        exp_addr.push_back(ad);
        exp_b[c][k*W +: W] = mem[ad];
      end
    end
  endtask

  task automatic run_req(input int ba, input int bb, input int row, input int col,
                         input int stall_chunk, input int stall_len, input bit rand_ready,
                         input int busy_start_cyc, input int rst_chunk, input bit chk_lat);
    int n = 0, stall_cnt = 0, hs_cyc = -100, done_cnt = 0, done_cyc = -1;
    int first_valid = -1, nrd = 0;
    bit finished = 1'b0;
    build_model(ba, bb, row, col);
    rd_log.delete();
    @(negedge clk);
    base_a = AW'(ba); base_b = AW'(bb); row_idx = 4'(row); col_idx = 4'(col);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == busy_start_cyc);
      if (start) begin
        base_a = AW'(ba + 5); base_b = AW'(bb + 7); row_idx = 4'(row + 3); col_idx = 4'(col + 1);
      end
      if (chunk_valid && n == stall_chunk && stall_cnt < stall_len) begin
        chunk_ready = 1'b0;
        stall_cnt++;
      end else if (rand_ready) chunk_ready = ($urandom_range(0, 2) != 0);
      else chunk_ready = 1'b1;

      if (mem_rd) begin
        rd_log.push_back(int'(mem_addr));
        if (exp_addr.size() == 0) check("extra_mem_rd", 1, 0);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
        if (chk_lat && nrd < 2 * CAP) check("rd_cycle", cyc, nrd + 1);
        nrd++;
      end

      if (chunk_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          if (chk_lat) check("first_valid_cycle", cyc, 6);
        end
        if (n >= NCH) check("chunk_count", n, NCH - 1);
        else begin
          check("chunk_a", chunk_a, exp_a[n]);
          check("chunk_b", chunk_b, exp_b[n]);
          check("chunk_unit", chunk_unit, n % UNITS);
          check("chunk_last", chunk_last, n == NCH - 1);
          if (n == rst_chunk) begin
            rst_n = 1'b0;
            #1;
            check("rst_mem_rd", mem_rd, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_chunk_valid", chunk_valid, 0);
            check("rst_chunk_last", chunk_last, 0);
            check("rst_chunk_unit", chunk_unit, 0);
            check("rst_chunk_a", chunk_a, 0);
            check("rst_chunk_b", chunk_b, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) begin
              @(negedge clk);
              check("post_rst_done", done, 0);
              check("post_rst_busy", busy, 0);
            end
            return;
          end
          if (chunk_ready) begin
            if (n == 0) begin obs_a0 = chunk_a; obs_b0 = chunk_b; end
            if (n == NCH - 1) begin obs_a7 = chunk_a; obs_b7 = chunk_b; obs_last7 = chunk_last; end
            hs_cyc = cyc;
            n++;
          end
        end
      end

      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check("done_after_last_hs", cyc, hs_cyc + 1);
          check("chunks_at_done", n, NCH);
        end
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) check("busy_after_done", busy, 0);
      if (done_cyc > 0 && cyc == done_cyc + 4) finished = 1'b1;
    end
    check("done_pulse_count", done_cnt, 1);
    check("reads_outstanding", exp_addr.size(), 0);
  endtask

  logic [CAP*W-1:0] ev;

  initial begin
    rst_n = 1'b0; start = 1'b0; chunk_ready = 1'b1; mem_rdata = '0;
    base_a = '0; base_b = '0; row_idx = '0; col_idx = '0;
    #3;
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_chunk_valid", chunk_valid, 0);
    check("reset_chunk_last", chunk_last, 0);
    check("reset_chunk_unit", chunk_unit, 0);
    check("reset_chunk_a", chunk_a, 0);
    check("reset_chunk_b", chunk_b, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity memory, single request with latency check.
    for (int a = 0; a < MSZ; a++) mem[a] = W'(a);
    run_req(0, 256, 1, 2, -1, 0, 1'b0, -1, -1, 1'b1);
    ev = {32'd17, 32'd16};  check("chunk0_a", obs_a0, ev);
    ev = {32'd274, 32'd258}; check("chunk0_b", obs_b0, ev);
    ev = {32'd31, 32'd30};  check("chunk7_a", obs_a7, ev);
    ev = {32'd498, 32'd482}; check("chunk7_b", obs_b7, ev);
    check("chunk7_last", obs_last7, 1);
    check("lat_addr0", rd_log[0], 16);
    check("lat_addr1", rd_log[1], 17);
    check("lat_addr2", rd_log[2], 258);
    check("lat_addr3", rd_log[3], 274);

    // Backpressure: 5 stalled cycles on chunk 3.
    run_req(0, 256, 1, 2, 3, 5, 1'b0, -1, -1, 1'b0);

    // Address wrap on the B column.
    for (int a = 0; a < MSZ; a++) mem[a] = $urandom;
    run_req($urandom_range(0, MSZ - 1), 1000, $urandom_range(0, DIM - 1), 0, -1, 0, 1'b0, -1, -1, 1'b0);
    check("wrap_b0", rd_log[2], 1000);
    check("wrap_b1", rd_log[3], 1016);
    check("wrap_b2", rd_log[6], 8);
    check("wrap_b3", rd_log[7], 24);

    // start while busy is ignored; following request restarts unit pointer at 0.
    run_req(40, 600, 7, 9, -1, 0, 1'b0, 10, -1, 1'b0);
    run_req(300, 5, 15, 15, -1, 0, 1'b0, -1, -1, 1'b0);

    // Reset during SEND of chunk 2, then a fresh request.
    run_req(123, 777, 4, 11, -1, 0, 1'b0, -1, 2, 1'b0);
    run_req(60, 900, 2, 3, -1, 0, 1'b0, -1, -1, 1'b0);

    // Randomized operands and ready.
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < MSZ; a++) mem[a] = $urandom;
      run_req($urandom_range(0, MSZ - 1), $urandom_range(0, MSZ - 1),
              $urandom_range(0, DIM - 1), $urandom_range(0, DIM - 1),
              $urandom_range(0, NCH - 1), $urandom_range(0, 6), 1'b1, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
